matrix_driver: RTL and testbench
================================

MATRIX_DRIVER -- requirements
Module: matrix_driver

Interface
REQ-001 The block SHALL have parameter MATRIX_SIZE, default 16, meaning the number of 16-bit words per matrix (legal values 2..256).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port sequence_i, input, array of MATRIX_SIZE x 16 bits: the parallel matrix from the upstream sequencer.
REQ-005 The block SHALL have port sequence_valid_i, input, 1 bit: a single-cycle pulse meaning sequence_i holds a new matrix.
REQ-006 The block SHALL have port sequence_send_o, output, 1 bit: a single-cycle pulse meaning the matrix was fully delivered downstream.
REQ-007 The block SHALL have port m_data_o, output, 16 bits: the stream data word.
REQ-008 The block SHALL have port m_valid_o, output, 1 bit: stream valid.
REQ-009 The block SHALL have port m_ready_i, input, 1 bit: stream ready from the DUT side.
REQ-010 The block SHALL have port m_last_o, output, 1 bit: high on the final word of a matrix.
REQ-011 The block SHALL have port m_id_o, output, 1 bit: matrix tag (0 = A, 1 = B).
REQ-012 The block SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port drop_o, output, 1 bit: sticky error flag for a rejected sequence_valid_i.
REQ-014 The block SHALL have port matrix_cnt_o, output, 8 bits: count of completed matrices, wrapping 255 -> 0.

Function
REQ-015 The block SHALL implement states IDLE, STREAM and DONE, encoded in a registered state variable.
REQ-016 In IDLE, when sequence_valid_i=1, the block SHALL capture all MATRIX_SIZE words of sequence_i into an internal buffer, clear word index idx to 0, and enter STREAM on the same edge.
REQ-017 In STREAM, the block SHALL drive m_valid_o=1, m_data_o=buf[idx], and m_last_o=(idx==MATRIX_SIZE-1); m_valid_o SHALL be 0 in IDLE and DONE.
REQ-018 A transfer SHALL occur on each edge where m_valid_o=1 and m_ready_i=1; idx SHALL increment per transfer except on the last word.
REQ-019 On the last-word transfer, the block SHALL enter DONE.
REQ-020 While m_valid_o=1 and m_ready_i=0, m_data_o, m_last_o and m_id_o SHALL hold stable; m_valid_o SHALL NOT drop before the transfer completes.
REQ-021 With m_ready_i held high, the block SHALL deliver one word per cycle: MATRIX_SIZE consecutive valid cycles starting the cycle after capture.
REQ-022 In DONE, the block SHALL assert sequence_send_o for exactly one cycle, toggle m_id_o, increment matrix_cnt_o, and return to IDLE on the next edge.
REQ-023 Latency SHALL be: last transfer at edge t, sequence_send_o high during cycle t..t+1, and a new sequence_valid_i accepted from edge t+2.
REQ-024 If sequence_valid_i=1 while the state is not IDLE, the block SHALL ignore it (buffer and stream unaffected) and set drop_o=1 until reset.
REQ-025 sequence_i SHALL be sampled only on the capture edge; later changes to it SHALL NOT affect the stream.
REQ-026 m_data_o SHALL equal 16'h0000 whenever m_valid_o=0.

Reset
REQ-027 On rst_i=1, regardless of clock, the block SHALL go to IDLE, clear idx, the buffer, m_valid_o, m_last_o, m_data_o, sequence_send_o, m_id_o, drop_o, busy_o and matrix_cnt_o to 0.
REQ-028 Reset asserted mid-STREAM SHALL abort the matrix with no sequence_send_o pulse; after release the block SHALL accept a new matrix normally.

Verification
REQ-029 Scenario 1: pulse valid with words 0..15 and m_ready_i=1 -> 16 consecutive beats, data 0..15, m_last_o only on 15, m_id_o=0, sequence_send_o pulse 1 cycle later, matrix_cnt_o=1.
REQ-030 Scenario 2: as scenario 1, with m_ready_i low on every other cycle -> data held stable while stalled, 16 transfers in order, no duplicates or skipped words.
REQ-031 Scenario 3: two matrices back to back (A values 100..115, B values 0..15), with the second valid driven at edge t+2 -> m_id_o=0 then 1, two sequence_send_o pulses, matrix_cnt_o=2, drop_o=0.
REQ-032 Scenario 4: a second valid pulse during STREAM -> drop_o=1 and sticky, current stream unchanged, no extra matrix emitted.
REQ-033 Scenario 5: assert rst_i asynchronously after beat 5 -> all outputs 0 immediately, no sequence_send_o pulse; a fresh matrix after release streams correctly with m_id_o=0.

Source files
------------

// File: rtl/matrix_driver.sv
// matrix_driver: captures a parallel matrix and streams it word by word over a valid/ready handshake
module matrix_driver #(
  parameter int MATRIX_SIZE = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] sequence_i [MATRIX_SIZE],
  input  logic        sequence_valid_i,
  output logic        sequence_send_o,
  output logic [15:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_last_o,
  output logic        m_id_o,
  output logic        busy_o,
  output logic        drop_o,
  output logic [7:0]  matrix_cnt_o
);
  localparam int IW = $clog2(MATRIX_SIZE);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic [15:0] mbuf [MATRIX_SIZE];
  logic last_word;
  assign idx_n = idx + 1'b1;
  assign last_word = idx == IW'(MATRIX_SIZE - 1);
  assign busy_o = state != IDLE;
  // capture on valid in IDLE, present one registered word per handshake, pulse send in DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      for (int i = 0; i < MATRIX_SIZE; i++) mbuf[i] <= '0;
      m_valid_o <= 1'b0;
      m_last_o <= 1'b0;
      m_data_o <= '0;
      sequence_send_o <= 1'b0;
      m_id_o <= 1'b0;
      drop_o <= 1'b0;
      matrix_cnt_o <= '0;
    end else begin
      if (sequence_valid_i && state != IDLE) drop_o <= 1'b1;
      case (state)
        IDLE: if (sequence_valid_i) begin
          mbuf <= sequence_i;
          idx <= '0;
          m_valid_o <= 1'b1;
          m_data_o <= sequence_i[0];
          m_last_o <= 1'b0;
          state <= STREAM;
        end
        STREAM: if (m_ready_i) begin
          if (last_word) begin
            m_valid_o <= 1'b0;
            m_data_o <= '0;
            m_last_o <= 1'b0;
            sequence_send_o <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx_n;
            m_data_o <= mbuf[idx_n];
            m_last_o <= idx_n == IW'(MATRIX_SIZE - 1);
          end
        end
        DONE: begin
          sequence_send_o <= 1'b0;
          m_id_o <= ~m_id_o;
          matrix_cnt_o <= matrix_cnt_o + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_driver.sv
// tb_matrix_driver: table-driven and directed checks of the matrix streaming driver
module tb_matrix_driver;
  localparam int MS = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sv = 1'b0;
  logic rdy = 1'b0;
  logic [15:0] seq [MS];
  logic send, valid, last, id, busy, drop;
  logic [15:0] data;
  logic [7:0] cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic rst, sv, rdy;
    logic [15:0] base;
    logic ev;
    logic [15:0] ed;
    logic el, es, eid, eb;
    logic [7:0] ec;
    logic edr;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  matrix_driver #(.MATRIX_SIZE(MS)) dut (
    .clk_i(clk), .rst_i(rst), .sequence_i(seq), .sequence_valid_i(sv),
    .sequence_send_o(send), .m_data_o(data), .m_valid_o(valid), .m_ready_i(rdy),
    .m_last_o(last), .m_id_o(id), .busy_o(busy), .drop_o(drop), .matrix_cnt_o(cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_out(input string t, input logic ev, input logic [15:0] ed, input logic el,
                           input logic es, input logic eid, input logic eb, input logic [7:0] ec, input logic edr);
    chk({t, ".valid"}, 32'(valid), 32'(ev));
    chk({t, ".data"}, 32'(data), 32'(ed));
    chk({t, ".last"}, 32'(last), 32'(el));
    chk({t, ".send"}, 32'(send), 32'(es));
    chk({t, ".id"}, 32'(id), 32'(eid));
    chk({t, ".busy"}, 32'(busy), 32'(eb));
    chk({t, ".cnt"}, 32'(cnt), 32'(ec));
    chk({t, ".drop"}, 32'(drop), 32'(edr));
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [15:0] base);
    for (int i = 0; i < MS; i++) seq[i] = base + 16'(i);
  endtask
  function automatic void add(input logic r, input logic s, input logic y, input logic [15:0] b,
                              input logic ev, input logic [15:0] ed, input logic el, input logic es,
                              input logic eid, input logic eb, input logic [7:0] ec, input logic edr);
    vec_t v;
    v.rst = r; v.sv = s; v.rdy = y; v.base = b;
    v.ev = ev; v.ed = ed; v.el = el; v.es = es; v.eid = eid; v.eb = eb; v.ec = ec; v.edr = edr;
    vq.push_back(v);
  endfunction
  function automatic void add_matrix(input logic [15:0] base, input bit stall, input logic mid, input logic [7:0] c);
    add(1'b0, 1'b1, 1'b1, base, 1'b0, 16'h0, 1'b0, 1'b0, mid, 1'b0, c, 1'b0);
    for (int k = 0; k < MS; k++) begin
      if (stall) add(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, base + 16'(k), k == MS - 1, 1'b0, mid, 1'b1, c, 1'b0);
      add(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, base + 16'(k), k == MS - 1, 1'b0, mid, 1'b1, c, 1'b0);
    end
    add(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, mid, 1'b1, c, 1'b0);
  endfunction
  initial begin
    add_matrix(16'd0, 1'b0, 1'b0, 8'd0);
    add_matrix(16'd0, 1'b1, 1'b1, 8'd1);
    add(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
    add_matrix(16'd100, 1'b0, 1'b0, 8'd0);
    add_matrix(16'd0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
    load(16'h0);
    #1;
    check_out("reset", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step;
    step;
    foreach (vq[i]) begin
      check_out($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].el, vq[i].es, vq[i].eid, vq[i].eb, vq[i].ec, vq[i].edr);
      rst = vq[i].rst;
      sv = vq[i].sv;
      rdy = vq[i].rdy;
      if (vq[i].sv) load(vq[i].base);
      else load(16'hDE00);
      step;
    end
    rst = 1'b0;
    sv = 1'b0;
    load(16'd200);
    sv = 1'b1;
    rdy = 1'b1;
    step;
    sv = 1'b0;
    load(16'hDE00);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drop_pre%0d.data", k), 32'(data), 32'(200 + k));
      step;
    end
    load(16'd500);
    sv = 1'b1;
    rdy = 1'b0;
    step;
    sv = 1'b0;
    load(16'hDE00);
    chk("drop.flag", 32'(drop), 32'd1);
    chk("drop.hold_data", 32'(data), 32'd203);
    chk("drop.hold_valid", 32'(valid), 32'd1);
    rdy = 1'b1;
    for (int k = 3; k < MS; k++) begin
      chk($sformatf("drop_beat%0d.data", k), 32'(data), 32'(200 + k));
      chk($sformatf("drop_beat%0d.last", k), 32'(last), 32'(k == MS - 1));
      step;
    end
    chk("drop.send", 32'(send), 32'd1);
    step;
    chk("drop.cnt", 32'(cnt), 32'd3);
    chk("drop.id", 32'(id), 32'd1);
    chk("drop.busy", 32'(busy), 32'd0);
    repeat (3) step;
    chk("drop.idle_valid", 32'(valid), 32'd0);
    chk("drop.idle_cnt", 32'(cnt), 32'd3);
    chk("drop.sticky", 32'(drop), 32'd1);
    load(16'd300);
    sv = 1'b1;
    step;
    sv = 1'b0;
    load(16'hDE00);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abort_beat%0d.data", k), 32'(data), 32'(300 + k));
      step;
    end
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_rst%0d.send", k), 32'(send), 32'd0);
      chk($sformatf("post_rst%0d.valid", k), 32'(valid), 32'd0);
      step;
    end
    load(16'd400);
    sv = 1'b1;
    step;
    sv = 1'b0;
    load(16'hDE00);
    for (int k = 0; k < MS; k++) begin
      chk($sformatf("fresh%0d.data", k), 32'(data), 32'(400 + k));
      chk($sformatf("fresh%0d.id", k), 32'(id), 32'd0);
      chk($sformatf("fresh%0d.last", k), 32'(last), 32'(k == MS - 1));
      step;
    end
    chk("fresh.send", 32'(send), 32'd1);
    step;
    chk("fresh.cnt", 32'(cnt), 32'd1);
    chk("fresh.id_toggled", 32'(id), 32'd1);
    chk("fresh.send_off", 32'(send), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
